// File: rtl/mdio_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdio_sched
// Purpose  : Shares one MDIO/MDC serial engine between a host register-access
//            port and an autonomous link-status poller. Each transaction is
//            walked through the engine's request / busy / read-strobe
//            handshake, and a per-PHY link-up vector is kept up to date so the
//            rest of the design never has to touch MDIO to learn link state.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset                 system clock (also the MDC rate), async active-low reset
//   host_req_i                 host request level, held until host_ack_o
//   host_op_i                  2'b10 read, 2'b01 write, anything else is rejected
//   host_phy_i, host_reg_i     host PHY / register address
//   host_wdata_i               host write data
//   host_ack_o                 one-cycle completion pulse
//   host_err_o                 valid with host_ack_o: illegal op or engine timeout
//   host_rdata_o               last successful host read data
//   poll_enb_i                 enables the link-status poller
//   link_up_o                  latched link bit per PHY
//   link_chg_o                 one-cycle pulse when any link_up_o bit changes
//   busy_o                     scheduler is not idle
//   req_enb_o                  engine request strobe
//   req_op_o, phy_addr_o,
//   reg_addr_o, data_phy_o     engine command fields, stable for the whole transaction
//   work_flag_i                engine busy
//   data_sta_i, sta_enb_i      engine read data and its valid strobe
// ============================================================================
module mdio_sched #(
  parameter logic [23:0] POLL_INTERVAL = 24'd1_000_000,
  parameter int          NUM_PHY       = 4,
  parameter logic [4:0]  PHY_BASE      = 5'd0,
  parameter logic [4:0]  POLL_REG      = 5'd1,
  parameter int          LINK_BIT      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_req_i,
  input  logic [1:0]         host_op_i,
  input  logic [4:0]         host_phy_i,
  input  logic [4:0]         host_reg_i,
  input  logic [15:0]        host_wdata_i,
  output logic               host_ack_o,
  output logic               host_err_o,
  output logic [15:0]        host_rdata_o,
  input  logic               poll_enb_i,
  output logic [NUM_PHY-1:0] link_up_o,
  output logic               link_chg_o,
  output logic               busy_o,
  output logic               req_enb_o,
  output logic [1:0]         req_op_o,
  output logic [4:0]         phy_addr_o,
  output logic [4:0]         reg_addr_o,
  output logic [15:0]        data_phy_o,
  input  logic               work_flag_i,
  input  logic [15:0]        data_sta_i,
  input  logic               sta_enb_i
);

  localparam int                 c_idx_w    = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;
  localparam logic [1:0]         c_op_read  = 2'b10;
  localparam logic [1:0]         c_op_write = 2'b01;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_PHY - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
  localparam logic [23:0]        c_timer_tc = POLL_INTERVAL - 24'd1;
  // Fourth consecutive WAIT_START cycle without work_flag aborts.
  localparam logic [1:0]         c_start_tmo = 2'd3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    FINISH     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           to_cnt_q;
  logic                 src_q;         // source of the transaction in flight: 0 host, 1 poll
  logic                 last_grant_q;  // 0 host, 1 poll
  logic [c_idx_w-1:0]   poll_idx_q;
  logic [23:0]          timer_q;
  logic                 poll_pend_q;
  logic [NUM_PHY-1:0]   link_up_q;
  logic                 link_chg_q;
  logic                 host_ack_q;
  logic                 host_err_q;
  logic [15:0]          host_rdata_q;
  logic [1:0]           req_op_q;
  logic [4:0]           phy_addr_q;
  logic [4:0]           reg_addr_q;
  logic [15:0]          data_phy_q;

  logic w_grant_host;
  logic w_grant_poll;
  logic w_fin;        // this edge enters FINISH
  logic w_fin_err;    // the transaction entering FINISH failed
  logic w_fin_poll;
  logic w_rd_ok;
  logic w_host_op_ok;
  logic w_timer_tc;

  assign w_host_op_ok = (host_op_i == c_op_read) || (host_op_i == c_op_write);
  assign w_timer_tc   = (timer_q == c_timer_tc);
  // A rejected host op enters FINISH straight from IDLE, before src_q is loaded.
  assign w_fin_poll   = (state_q != IDLE) && src_q;
  assign w_rd_ok      = (state_q == WAIT_DONE) && !w_fin_err && (req_op_q == c_op_read);

  always_comb begin
    state_d      = state_q;
    w_grant_host = 1'b0;
    w_grant_poll = 1'b0;
    w_fin        = 1'b0;
    w_fin_err    = 1'b0;
    case (state_q)
      IDLE: begin
        // On contention the source not granted last wins.
        if (host_req_i && (!poll_pend_q || last_grant_q)) begin
          w_grant_host = 1'b1;
        end else if (poll_pend_q) begin
          w_grant_poll = 1'b1;
        end
        if (w_grant_host) begin
          if (w_host_op_ok) begin
            state_d = ISSUE;
          end else begin
            state_d   = FINISH;
            w_fin     = 1'b1;
            w_fin_err = 1'b1;
          end
        end else if (w_grant_poll) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (work_flag_i) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == c_start_tmo) begin
          state_d   = FINISH;
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!work_flag_i) begin
          state_d   = FINISH;
          w_fin     = 1'b1;
          // A read that completes without its data strobe is treated as a timeout.
          w_fin_err = (req_op_q == c_op_read) && !sta_enb_i;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      to_cnt_q     <= 2'd0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b0;
      poll_idx_q   <= '0;
      timer_q      <= 24'd0;
      poll_pend_q  <= 1'b0;
      link_up_q    <= '0;
      link_chg_q   <= 1'b0;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
      host_rdata_q <= 16'd0;
      req_op_q     <= 2'd0;
      phy_addr_q   <= 5'd0;
      reg_addr_q   <= 5'd0;
      data_phy_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      host_ack_q <= 1'b0;
      host_err_q <= 1'b0;
      link_chg_q <= 1'b0;

      if (state_q == ISSUE) begin
        to_cnt_q <= 2'd0;
      end else if ((state_q == WAIT_START) && !work_flag_i) begin
        to_cnt_q <= to_cnt_q + 2'd1;
      end

      if (w_grant_host) begin
        src_q        <= 1'b0;
        last_grant_q <= 1'b0;
        req_op_q     <= host_op_i;
        phy_addr_q   <= host_phy_i;
        reg_addr_q   <= host_reg_i;
        data_phy_q   <= host_wdata_i;
      end else if (w_grant_poll) begin
        src_q        <= 1'b1;
        last_grant_q <= 1'b1;
        req_op_q     <= c_op_read;
        phy_addr_q   <= PHY_BASE + 5'(poll_idx_q);
        reg_addr_q   <= POLL_REG;
        data_phy_q   <= 16'd0;
      end

      // Results are registered on the edge into FINISH so they are visible
      // during the FINISH cycle itself.
      if (w_fin) begin
        if (w_fin_poll) begin
          if (!w_fin_err) begin
            link_up_q[poll_idx_q] <= data_sta_i[LINK_BIT];
            link_chg_q            <= link_up_q[poll_idx_q] ^ data_sta_i[LINK_BIT];
          end
          poll_idx_q <= (poll_idx_q == c_last_idx) ? '0 : poll_idx_q + c_idx_one;
        end else begin
          host_ack_q <= 1'b1;
          host_err_q <= w_fin_err;
          if (w_rd_ok) begin
            host_rdata_q <= data_sta_i;
          end
        end
      end

      // Poll timer; an expiry while a poll is still pending is simply dropped.
      if (!poll_enb_i) begin
        timer_q     <= 24'd0;
        poll_pend_q <= 1'b0;
      end else begin
        timer_q <= w_timer_tc ? 24'd0 : timer_q + 24'd1;
        if (w_fin && w_fin_poll) begin
          poll_pend_q <= 1'b0;
        end else if (w_timer_tc) begin
          poll_pend_q <= 1'b1;
        end
      end
    end
  end

  assign host_ack_o   = host_ack_q;
  assign host_err_o   = host_err_q;
  assign host_rdata_o = host_rdata_q;
  assign link_up_o    = link_up_q;
  assign link_chg_o   = link_chg_q;
  assign busy_o       = (state_q != IDLE);
  assign req_enb_o    = (state_q == ISSUE);
  assign req_op_o     = req_op_q;
  assign phy_addr_o   = phy_addr_q;
  assign reg_addr_o   = reg_addr_q;
  assign data_phy_o   = data_phy_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mdio_sched
// Purpose  : Self-checking bench for mdio_sched with a behavioural MDIO engine
//            (40-cycle frame by default) and a scoreboard of expected results.
// Revision : 1.0  initial release
// ============================================================================
module tb_mdio_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        host_req = 1'b0;
  logic [1:0]  host_op = 2'b00;
  logic [4:0]  host_phy = 5'd0;
  logic [4:0]  host_reg = 5'd0;
  logic [15:0] host_wdata = 16'd0;
  logic        host_ack, host_err;
  logic [15:0] host_rdata;
  logic        poll_enb = 1'b0;
  logic [3:0]  link_up;
  logic        link_chg, busy, req_enb;
  logic [1:0]  req_op;
  logic [4:0]  phy_addr, reg_addr;
  logic [15:0] data_phy;
  logic        work_flag;
  logic [15:0] data_sta;
  logic        sta_enb;

  always #5 clk = ~clk;

  mdio_sched #(
    .POLL_INTERVAL (24'd50),
    .NUM_PHY       (4),
    .PHY_BASE      (5'd0),
    .POLL_REG      (5'd1),
    .LINK_BIT      (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .host_req_i   (host_req),
    .host_op_i    (host_op),
    .host_phy_i   (host_phy),
    .host_reg_i   (host_reg),
    .host_wdata_i (host_wdata),
    .host_ack_o   (host_ack),
    .host_err_o   (host_err),
    .host_rdata_o (host_rdata),
    .poll_enb_i   (poll_enb),
    .link_up_o    (link_up),
    .link_chg_o   (link_chg),
    .busy_o       (busy),
    .req_enb_o    (req_enb),
    .req_op_o     (req_op),
    .phy_addr_o   (phy_addr),
    .reg_addr_o   (reg_addr),
    .data_phy_o   (data_phy),
    .work_flag_i  (work_flag),
    .data_sta_i   (data_sta),
    .sta_enb_i    (sta_enb)
  );

  // ---------------- engine model ----------------
  logic [15:0] mem [0:31][0:31];
  bit          eng_alive = 1'b1;
  int          eng_len = 40;
  logic        eng_busy;
  int          eng_cnt;
  logic [1:0]  eng_op;
  logic [4:0]  eng_phy, eng_reg;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      work_flag <= 1'b0;
      sta_enb   <= 1'b0;
      data_sta  <= 16'd0;
      eng_busy  <= 1'b0;
      eng_cnt   <= 0;
      eng_op    <= 2'd0;
      eng_phy   <= 5'd0;
      eng_reg   <= 5'd0;
    end else begin
      sta_enb <= 1'b0;
      if (eng_busy) begin
        if (eng_cnt == eng_len - 1) begin
          work_flag <= 1'b0;
          eng_busy  <= 1'b0;
          if (eng_op == 2'b10) begin
            sta_enb  <= 1'b1;
            data_sta <= mem[eng_phy][eng_reg];
          end
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end else if (req_enb && eng_alive) begin
        eng_busy  <= 1'b1;
        work_flag <= 1'b1;
        eng_cnt   <= 0;
        eng_op    <= req_op;
        eng_phy   <= phy_addr;
        eng_reg   <= reg_addr;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  typedef struct {
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] d;
    int          c;
  } req_t;

  typedef struct {
    int          lat;
    logic        err;
    logic [15:0] rd;
  } exp_t;

  req_t obs_q[$];
  req_t exp_req_q[$];
  exp_t exp_q[$];
  int   cyc = 0;
  int   chg_cnt = 0;
  int   ack_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (req_enb) obs_q.push_back(req_t'{req_op, phy_addr, reg_addr, data_phy, cyc});
    if (link_chg) chg_cnt = chg_cnt + 1;
    if (host_ack) ack_cnt = ack_cnt + 1;
  end

  // Drives one host transaction and reports what came back; no checking here.
  task automatic do_host(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] wd, output bit got, output int lat,
                         output logic err, output logic [15:0] rd, output int t0);
    @(posedge clk); #1;
    host_req = 1'b1; host_op = op; host_phy = phy; host_reg = rg; host_wdata = wd;
    t0 = cyc; got = 1'b0; lat = -1; err = 1'bx; rd = 16'hxxxx;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (host_ack) begin
        got = 1'b1; lat = cyc - t0; err = host_err; rd = host_rdata;
      end
    end
    host_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      if (!busy) ok = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    checks++; if ({host_ack, host_err, host_rdata} !== 18'd0) begin errors++;
      $display("FAIL reset_host got %0h exp 0", {host_ack, host_err, host_rdata}); end
    checks++; if ({link_up, link_chg, busy, req_enb} !== 7'd0) begin errors++;
      $display("FAIL reset_status got %0h exp 0", {link_up, link_chg, busy, req_enb}); end
    checks++; if ({req_op, phy_addr, reg_addr, data_phy} !== 28'd0) begin errors++;
      $display("FAIL reset_fields got %0h exp 0", {req_op, phy_addr, reg_addr, data_phy}); end
  endtask

  task automatic test_write;
    bit got; int lat, t0; logic err; logic [15:0] rd; exp_t e; req_t r, er;
    obs_q.delete();
    exp_q.push_back(exp_t'{43, 1'b0, 16'h0000});
    exp_req_q.push_back(req_t'{2'b01, 5'd3, 5'h10, 16'hA5C3, 1});
    do_host(2'b01, 5'd3, 5'h10, 16'hA5C3, got, lat, err, rd, t0);
    e = exp_q.pop_front(); er = exp_req_q.pop_front();
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL write_ack got none exp ack"); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL write_lat got %0d exp %0d", lat, e.lat); end
    checks++; if ({err, rd} !== {e.err, e.rd}) begin errors++;
      $display("FAIL write_err_rd got %0h exp %0h", {err, rd}, {e.err, e.rd}); end
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL write_nreq got %0d exp 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      r = obs_q.pop_front();
      checks++; if ({r.op, r.phy, r.rg, r.d} !== {er.op, er.phy, er.rg, er.d}) begin errors++;
        $display("FAIL write_fields got %0h exp %0h", {r.op, r.phy, r.rg, r.d}, {er.op, er.phy, er.rg, er.d}); end
      checks++; if (r.c - t0 !== er.c) begin errors++; $display("FAIL write_req_lat got %0d exp %0d", r.c - t0, er.c); end
    end
  endtask

  task automatic test_read;
    bit got; int lat, t0; logic err; logic [15:0] rd; exp_t e; req_t r, er;
    obs_q.delete();
    exp_q.push_back(exp_t'{43, 1'b0, 16'h1234});
    exp_req_q.push_back(req_t'{2'b10, 5'd5, 5'd2, 16'h0000, 1});
    exp_q.push_back(exp_t'{43, 1'b0, 16'h1234});
    exp_req_q.push_back(req_t'{2'b01, 5'd5, 5'd3, 16'hBEEF, 1});
    for (int k = 0; k < 2; k++) begin
      if (k == 0) do_host(2'b10, 5'd5, 5'd2, 16'h0000, got, lat, err, rd, t0);
      else        do_host(2'b01, 5'd5, 5'd3, 16'hBEEF, got, lat, err, rd, t0);
      e = exp_q.pop_front(); er = exp_req_q.pop_front();
      checks++; if ({got, err, rd} !== {1'b1, e.err, e.rd}) begin errors++;
        $display("FAIL read%0d_result got %0h exp %0h", k, {got, err, rd}, {1'b1, e.err, e.rd}); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL read%0d_lat got %0d exp %0d", k, lat, e.lat); end
      if (obs_q.size() > 0) r = obs_q.pop_front(); else r = req_t'{2'b00, 5'd0, 5'd0, 16'd0, -1};
      checks++; if ({r.op, r.phy, r.rg, r.d} !== {er.op, er.phy, er.rg, er.d}) begin errors++;
        $display("FAIL read%0d_fields got %0h exp %0h", k, {r.op, r.phy, r.rg, r.d}, {er.op, er.phy, er.rg, er.d}); end
    end
  endtask

  task automatic test_illegal;
    bit got; int lat, t0; logic err; logic [15:0] rd; exp_t e;
    for (int k = 0; k < 2; k++) begin
      obs_q.delete();
      exp_q.push_back(exp_t'{1, 1'b1, 16'h1234});
      do_host((k == 0) ? 2'b11 : 2'b00, 5'd2, 5'd9, 16'h5555, got, lat, err, rd, t0);
      e = exp_q.pop_front();
      checks++; if ({got, err, rd} !== {1'b1, e.err, e.rd}) begin errors++;
        $display("FAIL illegal%0d_result got %0h exp %0h", k, {got, err, rd}, {1'b1, e.err, e.rd}); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL illegal%0d_lat got %0d exp %0d", k, lat, e.lat); end
      checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL illegal%0d_nreq got %0d exp 0", k, obs_q.size()); end
    end
  endtask

  task automatic test_timeout;
    bit got; int lat, t0; logic err; logic [15:0] rd; exp_t e;
    obs_q.delete();
    eng_alive = 1'b0;
    exp_q.push_back(exp_t'{6, 1'b1, 16'h1234});
    do_host(2'b10, 5'd7, 5'd4, 16'h0000, got, lat, err, rd, t0);
    e = exp_q.pop_front();
    checks++; if ({got, err, rd} !== {1'b1, e.err, e.rd}) begin errors++;
      $display("FAIL timeout_result got %0h exp %0h", {got, err, rd}, {1'b1, e.err, e.rd}); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL timeout_lat got %0d exp %0d", lat, e.lat); end
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL timeout_nreq got %0d exp 1", obs_q.size()); end
    eng_alive = 1'b1;
  endtask

  task automatic test_poll;
    int c0; bit ok; req_t r, er;
    obs_q.delete();
    c0 = chg_cnt;
    for (int i = 0; i < 5; i++) exp_req_q.push_back(req_t'{2'b10, 5'(i % 4), 5'd1, 16'h0000, 0});
    poll_enb = 1'b1;
    for (int i = 0; i < 2000 && obs_q.size() < 5; i++) begin @(posedge clk); #1; end
    wait_idle(ok);
    checks++; if ({ok, obs_q.size() >= 5} !== 2'b11) begin errors++;
      $display("FAIL poll_count got %0d polls idle %0d exp 5 polls idle 1", obs_q.size(), ok); end
    for (int i = 0; i < 5; i++) begin
      er = exp_req_q.pop_front();
      if (obs_q.size() > 0) r = obs_q.pop_front(); else r = req_t'{2'b00, 5'd31, 5'd31, 16'hFFFF, -1};
      checks++; if ({r.op, r.phy, r.rg, r.d} !== {er.op, er.phy, er.rg, er.d}) begin errors++;
        $display("FAIL poll%0d_fields got %0h exp %0h", i, {r.op, r.phy, r.rg, r.d}, {er.op, er.phy, er.rg, er.d}); end
    end
    checks++; if (link_up !== 4'b1101) begin errors++; $display("FAIL poll_link_up got %b exp 1101", link_up); end
    checks++; if (chg_cnt - c0 !== 3) begin errors++; $display("FAIL poll_link_chg got %0d exp 3", chg_cnt - c0); end
  endtask

  task automatic test_arbitration;
    int a0, nhost; bit ok; bit is_host [6];
    eng_len = 60;
    wait_idle(ok);
    obs_q.delete();
    a0 = ack_cnt;
    host_req = 1'b1; host_op = 2'b10; host_phy = 5'd16; host_reg = 5'd31; host_wdata = 16'd0;
    for (int i = 0; i < 3000 && obs_q.size() < 6; i++) begin @(posedge clk); #1; end
    host_req = 1'b0;
    wait_idle(ok);
    checks++; if ({ok, obs_q.size()} !== {1'b1, 32'd6}) begin errors++;
      $display("FAIL arb_grants got %0d idle %0d exp 6 idle 1", obs_q.size(), ok); end
    nhost = 0;
    for (int k = 0; k < 6; k++) begin
      is_host[k] = (k < obs_q.size()) ? (obs_q[k].phy == 5'd16) : 1'b0;
      if (is_host[k]) nhost++;
    end
    for (int k = 1; k < 6; k++) begin
      checks++; if (is_host[k] === is_host[k-1]) begin errors++;
        $display("FAIL arb_alternate%0d got host=%0d exp host=%0d", k, is_host[k], !is_host[k-1]); end
    end
    checks++; if (nhost !== 3) begin errors++; $display("FAIL arb_host_grants got %0d exp 3", nhost); end
    checks++; if (ack_cnt - a0 !== 3) begin errors++; $display("FAIL arb_acks got %0d exp 3", ack_cnt - a0); end
    checks++; if (host_rdata !== 16'h5A5A) begin errors++; $display("FAIL arb_rdata got %0h exp 5a5a", host_rdata); end
    eng_len = 40;
  endtask

  task automatic test_poll_disable;
    logic [3:0] exp_link, exp_after; int c0, p; bit ok;
    exp_link = 4'b1101;
    for (int i = 0; i < 4; i++) mem[i][1] = exp_link[i] ? 16'h0000 : 16'h0004;
    wait_idle(ok);
    obs_q.delete();
    c0 = chg_cnt;
    for (int i = 0; i < 300 && obs_q.size() < 1; i++) begin @(posedge clk); #1; end
    p = (obs_q.size() > 0) ? int'(obs_q[0].phy) : 31;
    checks++; if ((p < 4) !== 1'b1) begin errors++; $display("FAIL pdis_poll_seen got phy %0d exp 0..3", p); end
    repeat (10) @(posedge clk);
    #1 poll_enb = 1'b0;
    wait_idle(ok);
    exp_after = exp_link ^ (4'b0001 << (p & 3));
    checks++; if (link_up !== exp_after) begin errors++; $display("FAIL pdis_link_up got %b exp %b", link_up, exp_after); end
    checks++; if (chg_cnt - c0 !== 1) begin errors++; $display("FAIL pdis_link_chg got %0d exp 1", chg_cnt - c0); end
    repeat (200) @(posedge clk);
    #1;
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL pdis_no_more_polls got %0d exp 1", obs_q.size()); end
  endtask

  task automatic test_reset_mid;
    int a0;
    @(posedge clk); #1;
    host_req = 1'b1; host_op = 2'b10; host_phy = 5'd5; host_reg = 5'd2; host_wdata = 16'd0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %0d exp 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if ({host_ack, host_err, host_rdata, link_up, link_chg, busy, req_enb} !== 25'd0) begin errors++;
      $display("FAIL rmid_outputs got %0h exp 0", {host_ack, host_err, host_rdata, link_up, link_chg, busy, req_enb}); end
    checks++; if ({req_op, phy_addr, reg_addr, data_phy} !== 28'd0) begin errors++;
      $display("FAIL rmid_fields got %0h exp 0", {req_op, phy_addr, reg_addr, data_phy}); end
    a0 = ack_cnt;
    obs_q.delete();
    @(negedge clk);
    host_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checks++; if (ack_cnt - a0 !== 0) begin errors++; $display("FAIL rmid_no_ack got %0d exp 0", ack_cnt - a0); end
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL rmid_no_req got %0d exp 0", obs_q.size()); end
  endtask

  initial begin
    for (int p = 0; p < 32; p++) for (int r = 0; r < 32; r++) mem[p][r] = 16'hDEAD;
    mem[5][2]   = 16'h1234;
    mem[16][31] = 16'h5A5A;
    mem[0][1]   = 16'h0004;
    mem[1][1]   = 16'h0000;
    mem[2][1]   = 16'h0004;
    mem[3][1]   = 16'h0004;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    test_reset;
    test_write;
    test_read;
    test_illegal;
    test_timeout;
    test_poll;
    test_arbitration;
    test_poll_disable;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdio_sched.md
# mdio_sched

Command scheduler in front of the MDIO/MDC serial engine of the quad-PHY (VSC8224) board. It shares the single engine between a host register-access port and an autonomous link-status poller, and sequences each transaction through the engine's request/busy/read-strobe handshake. It also maintains a per-PHY link-up vector that the rest of the design reads without touching MDIO.

## Interface
- POLL_INTERVAL, 24'd1_000_000: clk cycles between poll reads.
- NUM_PHY, 4: number of PHYs polled, indices 0..NUM_PHY-1.
- PHY_BASE, 5'd0: MDIO address of PHY index 0; PHY i is at PHY_BASE+i.
- POLL_REG, 5'd1: register read by the poller (status register).
- LINK_BIT, 2: bit of POLL_REG giving link-up.
- clk  in  1  system clock, also the MDC rate of the engine.
- reset  in  1  asynchronous, active-low.
- host_req  in  1  host request, level; held until host_ack.
- host_op  in  2  2'b10 read, 2'b01 write; other codes rejected.
- host_phy, host_reg  in  5 each  PHY and register address.
- host_wdata  in  16  write data.
- host_ack  out  1  one-cycle completion pulse.
- host_err  out  1  valid with host_ack: illegal op or engine timeout.
- host_rdata  out  16  read data; valid with host_ack, held until next host read completes.
- poll_enb  in  1  enables the poller.
- link_up  out  NUM_PHY  latched link bit per PHY.
- link_chg  out  1  one-cycle pulse when any link_up bit changes.
- busy  out  1  high whenever state != IDLE.
- req_enb  out  1  engine request strobe.
- req_op  out  2  engine op code.
- phy_addr, reg_addr  out  5 each  engine addresses.
- data_phy  out  16  engine write data.
- work_flag  in  1  engine busy.
- data_sta  in  16  engine read data.
- sta_enb  in  1  engine read-data-valid pulse.

## Operation
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, FINISH.
- IDLE: arbitrate between host_req and poll_pend. If only one is pending, it wins. If both are pending, the winner alternates: a last_grant register (0 = host, 1 = poll; reset 0) gives priority to the source not granted last. The winner's op and addresses are latched into req_op, phy_addr, reg_addr, data_phy. Poll uses op 2'b10, PHY_BASE+poll_idx, POLL_REG, data 0. Go to ISSUE.
- Illegal host_op (2'b00 or 2'b11) while the host wins: no engine access. Go straight to FINISH with host_err=1.
- ISSUE: req_enb=1 for exactly one cycle. Go to WAIT_START.
- WAIT_START: wait for work_flag=1, then go to WAIT_DONE. If work_flag stays 0 for 4 cycles, abort to FINISH with the timeout error.
- WAIT_DONE: wait for work_flag=0; that cycle is completion. For reads, capture data_sta when sta_enb=1 in that cycle. If sta_enb=0, flag a timeout error. Go to FINISH.
- FINISH (one cycle): host_ack, host_err and host_rdata are registered here.
  - Poll result: link_up[poll_idx] <= data_sta[LINK_BIT]; link_chg=1 if the value changed; poll_idx wraps NUM_PHY-1 -> 0; clear poll_pend.
  - Poll error: link_up is unchanged, and poll_idx still advances.
  - Return to IDLE.
- req_op, phy_addr, reg_addr, data_phy hold their values from ISSUE through FINISH. req_enb is 0 in every state except ISSUE.
- Poll timer: counts 0..POLL_INTERVAL-1 while poll_enb=1. At terminal count it sets poll_pend and restarts.
  - If poll_pend is already set at terminal count, the expiry is dropped (no queueing).
  - poll_enb=0 clears the timer and poll_pend. A poll already in flight completes and updates link_up.
- Host fields are sampled only in IDLE; changes while busy are ignored. After host_ack, host_req must drop or re-present a new request; it is re-arbitrated from IDLE the next cycle.

## Timing
- Reset values: all outputs 0, state IDLE, poll_idx 0, timer 0, poll_pend 0, last_grant 0.
- Host request seen in IDLE at cycle n:
  - req_enb is high at n+1.
  - Engine raises work_flag at n+2.
  - With a 40-bit engine frame, work_flag falls at n+42 (sta_enb is also high at n+42 for reads).
  - FINISH is at n+43, and host_ack is visible at n+43.
- Back-to-back transactions: minimum 1 IDLE cycle between FINISH and the next ISSUE.
- Host rejected op: host_ack at n+1 (IDLE -> FINISH).
- Timeout: host_ack with host_err at n+6 (ISSUE n+1, WAIT_START n+2..n+5, FINISH n+6).
- Reset asserted mid-transaction: immediate return to reset values. No ack is issued and the engine request is dropped; the engine has its own reset.

## Test plan
- Host write (op 01, phy 3, reg 0x10, data 0xA5C3), poll_enb=0, engine model:
  - req_enb one pulse at n+1 with fields 01/3/0x10/0xA5C3.
  - host_ack at n+43, host_err=0.
- Host read, engine returns 0x1234:
  - host_rdata=0x1234 with host_ack at n+43.
  - host_rdata holds 0x1234 through a following write.
- poll_enb=1, POLL_INTERVAL=50, PHY status values 0x0004, 0x0000, 0x0004, 0x0004:
  - Reads go to PHY 0,1,2,3 at reg 1, then wrap to PHY 0.
  - link_up=4'b1101 after four polls; link_chg pulses only on changed bits.
- Host and poll both pending continuously: grants alternate host, poll, host, poll; neither is starved.
- Illegal op 2'b11: host_ack and host_err at n+1, no req_enb.
- Engine never raises work_flag: host_err at n+6.
- Reset pulled at n+20 of a read: all outputs return to 0 and no ack is issued.
- Clearing poll_enb mid-poll: the in-flight poll completes and updates link_up, and no further polls are issued.
